// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: host req/done handshake, decode/ALU inputs and fetch-side
// controls of the fetch_sequencer, bundled into one port.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int OFF_W  = 5,
    parameter int CNT_W  = 16
);
    // Host handshake
    logic                     req;
    logic [1:0]               prog_sel;
    logic                     done;
    logic                     busy;

    // Decode / ALU information for the current instruction
    logic                     dec_branch;
    logic                     dec_halt;
    logic                     cond_flag;
    logic signed [OFF_W-1:0]  dec_offset;

    // Controls toward fetch and PC
    logic                     start;
    logic [ADDR_W-1:0]        start_address;
    logic                     branch;
    logic                     taken;
    logic signed [OFF_W-1:0]  offset;
    logic                     halt;

    // Status
    logic [CNT_W-1:0]         instr_count;
    logic                     timeout;

    // master: the sequencer itself; slave: the host/decode/fetch environment.
    modport master (
        input  req, prog_sel, dec_branch, dec_halt, cond_flag, dec_offset,
        output done, busy, start, start_address, branch, taken, offset, halt,
               instr_count, timeout
    );

    modport slave (
        output req, prog_sel, dec_branch, dec_halt, cond_flag, dec_offset,
        input  done, busy, start, start_address, branch, taken, offset, halt,
               instr_count, timeout
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: launches a program on fetch, forwards decoded branch/halt
// controls and counts executed instructions. Optional watchdog: FETCH_SEQ_WATCHDOG_EN.
module fetch_sequencer #(
    parameter int ADDR_W     = 7,
    parameter int OFF_W      = 5,
    parameter int START0     = 0,
    parameter int START1     = 32,
    parameter int START2     = 64,
    parameter int START3     = 96,
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_HALTED
    } state_t;

`ifdef FETCH_SEQ_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    // Count value seen during the last RUN cycle the watchdog allows.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    count_q;
    logic                wdog_fire;
    logic                run_halt;
    logic                fwd_branch;

    function automatic logic [ADDR_W-1:0] start_of(input logic [1:0] sel);
        logic [ADDR_W-1:0] addr;
        case (sel)
            2'd0:    addr = ADDR_W'(START0);
            2'd1:    addr = ADDR_W'(START1);
            2'd2:    addr = ADDR_W'(START2);
            default: addr = ADDR_W'(START3);
        endcase
        return addr;
    endfunction

    // A decoded halt takes priority; the watchdog only fires on a non-halt cycle.
    assign wdog_fire  = WDOG_EN && (state == ST_RUN) && (count_q == WDOG_LAST) && !bus.dec_halt;
    assign run_halt   = (state == ST_RUN) && (bus.dec_halt || wdog_fire);
    assign fwd_branch = (state == ST_RUN) && bus.dec_branch && !run_halt;

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (run_halt) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!bus.req) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.start  = 1'b0;
        bus.branch = 1'b0;
        bus.taken  = 1'b0;
        bus.offset = '0;
        bus.halt   = 1'b0;
        bus.done   = 1'b0;
        bus.busy   = 1'b0;
        case (state)
            ST_START: begin
                bus.start = 1'b1;
                bus.busy  = 1'b1;
            end
            ST_RUN: begin
                bus.busy   = 1'b1;
                bus.halt   = run_halt;
                bus.branch = fwd_branch;
                bus.taken  = fwd_branch && bus.cond_flag;
                bus.offset = fwd_branch ? bus.dec_offset : '0;
            end
            ST_HALTED: begin
                bus.halt = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Start address is resolved at acceptance so later prog_sel changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= ADDR_W'(START0);
            count_q <= '0;
        end else begin
            if (state == ST_IDLE && bus.req) begin
                addr_q <= start_of(bus.prog_sel);
            end
            if (state == ST_START) begin
                count_q <= '0;
            end else if (state == ST_RUN && count_q != '1) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.start_address = addr_q;
    assign bus.instr_count   = count_q;

`ifdef FETCH_SEQ_WATCHDOG_EN
    logic timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (state == ST_START) begin
            timeout_q <= 1'b0;
        end else if (wdog_fire) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule
